regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the decode-stage register file of the SIMPLE core: a multi-register file with two read ports and one write-back port.
- Adds what the current stage lacks: reset, a per-register pending-write scoreboard, RAW/WAW hazard stalls, write-back-to-read bypass, an optional hardwired-zero r0, and a debug read port.
- Sits between instruction decode (issue side) and the write-back stage.

Parameters:
- WIDTH, 16, data width of each register.
- ADDRW, 3, register address width; NREG = 2**ADDRW registers.
- ZERO_R0, 0, 1 = r0 reads as 0, ignores writes, and is never marked busy.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- resetn  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_use1  in  1  instruction reads raddr1.
- issue_use2  in  1  instruction reads raddr2.
- raddr1  in  ADDRW  source register 1.
- raddr2  in  ADDRW  source register 2.
- issue_wr  in  1  instruction will write issue_dst.
- issue_dst  in  ADDRW  destination register.
- issue_ready  out  1  combinational; no hazard, so issue may fire.
- rdata1  out  WIDTH  registered operand 1.
- rdata2  out  WIDTH  registered operand 2.
- rvalid  out  1  operands on rdata1/rdata2 belong to the last fired issue.
- wb_valid  in  1  write-back strobe.
- wb_addr  in  ADDRW  write-back target.
- wb_data  in  WIDTH  write-back value.
- busy_vec  out  NREG  scoreboard, bit i = register i has a pending write.
- wb_err  out  1  sticky; set on write-back to a non-busy register.
- dbg_sel  in  ADDRW  debug register select.
- dbg_data  out  WIDTH  combinational contents of register dbg_sel; no bypass.

Behaviour:
- Reset (async, resetn=0): all registers 0; busy_vec 0; rdata1/rdata2 0; rvalid 0; wb_err 0. Reset mid-operation discards pending writes and in-flight operands.
- wbhit(a) = wb_valid && wb_addr==a (false for a=0 when ZERO_R0=1).
- Hazard terms:
  - raw1 = issue_use1 && busy[raddr1] && !wbhit(raddr1); raw2 is the same for port 2.
  - waw = issue_wr && busy[issue_dst] && !wbhit(issue_dst).
- issue_ready = !(raw1 || raw2 || waw). It is independent of issue_valid.
- fire = issue_valid && issue_ready.
- Read latency is 1 cycle. On fire, each rdataN <= wbhit(raddrN) ? wb_data : reg[raddrN] (bypass). A port with issue_useN=0 loads 0. rvalid <= fire.
- Without fire, rdata1/rdata2 hold their values and rvalid <= 0.
- Write-back: if wb_valid (and not r0 with ZERO_R0=1), reg[wb_addr] <= wb_data and busy[wb_addr] <= 0.
  - A write-back with busy[wb_addr]=0 still writes, and sets wb_err (held until reset).
- Scoreboard set: on fire with issue_wr=1, busy[issue_dst] <= 1.
  - Same-cycle set and clear of the same bit: set wins.
  - With ZERO_R0=1, dst 0 is never set.
- ZERO_R0=1: any read of r0 (rdata, dbg_data) returns 0, and r0 raises no hazard.
- Only one write per register is outstanding at a time; the WAW stall enforces this.

Test Plan:
- Reset then dbg_sel=0..7 -> dbg_data=0 for all; busy_vec=0; issue_ready=1.
- Write-back r3=16'h00A5, then issue raddr1=3, use1=1 -> next cycle rdata1=16'h00A5, rvalid=1.
- Fire issue_wr=1, dst=2 -> busy_vec=8'h04.
  - Next cycle issue raddr1=2, use1=1 -> issue_ready=0 held.
  - Write-back r2=16'h1234 in the stall cycle -> issue_ready=1 that same cycle, fire, rdata1=16'h1234 (bypass), busy_vec=0.
- busy[5]=1; issue dst=5 with issue_wr=1 alongside wb r5 -> fire accepted, busy[5] remains 1, r5 holds the wb value.
- ZERO_R0=1: wb r0=16'hFFFF -> dbg_data(0)=0, busy[0]=0, wb_err=0.
  - Then wb r6 with busy[6]=0 -> wb_err=1 and sticky until resetn low.
- resetn pulsed low while busy_vec=8'h0C and rvalid=1 -> immediately busy_vec=0, rvalid=0, rdata1/rdata2=0, registers 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Two-read / one-write register file with a pending-write scoreboard,
// RAW/WAW issue stalls, write-back bypass and an optional hardwired-zero r0.
module regfile_scoreboard #(
  parameter int WIDTH   = 16,
  parameter int ADDRW   = 3,
  parameter int ZERO_R0 = 0
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  issue_valid,
  input  logic                  issue_use1,
  input  logic                  issue_use2,
  input  logic [ADDRW-1:0]      raddr1,
  input  logic [ADDRW-1:0]      raddr2,
  input  logic                  issue_wr,
  input  logic [ADDRW-1:0]      issue_dst,
  output logic                  issue_ready,
  output logic [WIDTH-1:0]      rdata1,
  output logic [WIDTH-1:0]      rdata2,
  output logic                  rvalid,
  input  logic                  wb_valid,
  input  logic [ADDRW-1:0]      wb_addr,
  input  logic [WIDTH-1:0]      wb_data,
  output logic [(1<<ADDRW)-1:0] busy_vec,
  output logic                  wb_err,
  input  logic [ADDRW-1:0]      dbg_sel,
  output logic [WIDTH-1:0]      dbg_data
);

  localparam int NREG = 1 << ADDRW;
  localparam bit Z0   = (ZERO_R0 != 0);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  logic [WIDTH-1:0] rdata1_q, rdata1_d;
  logic [WIDTH-1:0] rdata2_q, rdata2_d;
  logic             rvalid_q;
  logic             wb_err_q, wb_err_d;

  logic             wb_en;
  logic             hit1, hit2, hit_dst;
  logic             raw1, raw2, waw, fire, set_en;
  logic [WIDTH-1:0] reg1, reg2;

  // A write-back aimed at a hardwired r0 is treated as if it never happened.
  assign wb_en   = wb_valid && !(Z0 && wb_addr == '0);
  assign hit1    = wb_en && (wb_addr == raddr1);
  assign hit2    = wb_en && (wb_addr == raddr2);
  assign hit_dst = wb_en && (wb_addr == issue_dst);

  assign raw1 = issue_use1 && busy_q[raddr1] && !hit1;
  assign raw2 = issue_use2 && busy_q[raddr2] && !hit2;
  assign waw  = issue_wr && busy_q[issue_dst] && !hit_dst;

  assign issue_ready = !(raw1 || raw2 || waw);
  assign fire        = issue_valid && issue_ready;
  assign set_en      = fire && issue_wr && !(Z0 && issue_dst == '0);

  assign reg1 = (Z0 && raddr1 == '0) ? '0 : regs_q[raddr1];
  assign reg2 = (Z0 && raddr2 == '0) ? '0 : regs_q[raddr2];

  always_comb begin
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    if (fire) begin
      rdata1_d = !issue_use1 ? '0 : (hit1 ? wb_data : reg1);
      rdata2_d = !issue_use2 ? '0 : (hit2 ? wb_data : reg2);
    end
  end

  // Clear from write-back first so a same-cycle issue to that register wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_en)  busy_d[wb_addr]   = 1'b0;
    if (set_en) busy_d[issue_dst] = 1'b1;
  end

  assign wb_err_d = wb_err_q || (wb_en && !busy_q[wb_addr]);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q   <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      rvalid_q <= 1'b0;
      wb_err_q <= 1'b0;
    end else begin
      if (wb_en) regs_q[wb_addr] <= wb_data;
      busy_q   <= busy_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      rvalid_q <= fire;
      wb_err_q <= wb_err_d;
    end
  end

  assign rdata1   = rdata1_q;
  assign rdata2   = rdata2_q;
  assign rvalid   = rvalid_q;
  assign busy_vec = busy_q;
  assign wb_err   = wb_err_q;
  assign dbg_data = (Z0 && dbg_sel == '0) ? '0 : regs_q[dbg_sel];

endmodule
